// File: rtl/horda_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | horda_ctrl_if : control/status bundle between the wave controller and      |
// |                 the rest of the game (pause, live flags, formation state). |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface horda_ctrl_if #(
  parameter int N = 8
);
  logic         pausa;
  logic [N-1:0] vivo;
  logic [9:0]   x_base;
  logic [9:0]   y_base;
  logic         sentido;
  logic         passo;
  logic [3:0]   vivos;
  logic         onda_limpa;
  logic         invadiu;

  modport master (
    output pausa, vivo,
    input  x_base, y_base, sentido, passo, vivos, onda_limpa, invadiu
  );

  modport slave (
    input  pausa, vivo,
    output x_base, y_base, sentido, passo, vivos, onda_limpa, invadiu
  );
endinterface

`default_nettype wire

// File: rtl/horda_ctrl.sv
// +----------------------------------------------------------------------------+
// | horda_ctrl : enemy-wave formation controller; shared tick, bounding-box    |
// |              scan, step/drop-reverse decision, speed-up and end flags.     |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module horda_ctrl #(
  parameter int COLS      = 4,
  parameter int ROWS      = 2,
  parameter int LARGURA   = 30,
  parameter int ALTURA    = 20,
  parameter int PASSO_COL = 50,
  parameter int PASSO_LIN = 40,
  parameter int DX        = 2,
  parameter int DY        = 20,
  parameter int X0        = 100,
  parameter int Y0        = 40,
  parameter int Y_LIMITE  = 440,
  parameter int DIV_MIN   = 100000,
  parameter int DIV_STEP  = 40000
) (
  input  wire logic     CLOCK_50,
  input  wire logic     resetInimigo,
  horda_ctrl_if.slave   bus
);

  localparam int N  = COLS * ROWS;
  localparam int IW = (N > 1)    ? $clog2(N)    : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [23:0] PERIODO_RST = 24'(DIV_MIN + N * DIV_STEP);
  localparam logic [10:0] TELA_X      = 11'd640;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    MOVE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [23:0]   tick;
  logic [23:0]   periodo;
  logic [IW-1:0] idx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cmin;
  logic [CW-1:0] cmax;
  logic [RW-1:0] rmax;
  logic [3:0]    cnt;

  logic [9:0] x_base;
  logic [9:0] y_base;
  logic       sentido;
  logic       passo;
  logic [3:0] vivos;
  logic       onda_limpa;
  logic       invadiu;

  logic        sticky;
  logic        count_en;
  logic        tick_done;
  logic        scan_last;
  logic        live;
  logic [10:0] x_right;
  logic [10:0] x_left;
  logic [10:0] y_bottom;
  logic        rule_clear;
  logic        rule_inv;
  logic        rule_drop_r;
  logic        rule_drop_l;

  assign bus.x_base     = x_base;
  assign bus.y_base     = y_base;
  assign bus.sentido    = sentido;
  assign bus.passo      = passo;
  assign bus.vivos      = vivos;
  assign bus.onda_limpa = onda_limpa;
  assign bus.invadiu    = invadiu;

  assign sticky    = onda_limpa | invadiu;
  assign count_en  = ~bus.pausa & ~sticky;
  assign tick_done = (tick == periodo - 24'd1);
  assign scan_last = (idx == IW'(N - 1));
  assign live      = bus.vivo[idx];

  // Bounds are widened to 11 bits so sums past 1023 never wrap.
  assign x_right  = {1'b0, x_base} + 11'(cmax * PASSO_COL) + 11'(LARGURA + DX);
  assign x_left   = {1'b0, x_base} + 11'(cmin * PASSO_COL);
  assign y_bottom = {1'b0, y_base} + 11'(rmax * PASSO_LIN) + 11'(ALTURA);

  assign rule_clear  = (cnt == 4'd0);
  assign rule_inv    = (y_bottom >= 11'(Y_LIMITE));
  assign rule_drop_r = sentido  & (x_right > TELA_X);
  assign rule_drop_l = ~sentido & (x_left < 11'(DX));

  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_en && tick_done) state_next = SCAN;
      SCAN:    if (scan_last) state_next = MOVE;
      MOVE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo) begin
      tick       <= 24'd0;
      periodo    <= PERIODO_RST;
      idx        <= '0;
      col        <= '0;
      row        <= '0;
      cmin       <= CW'(COLS - 1);
      cmax       <= '0;
      rmax       <= '0;
      cnt        <= 4'd0;
      x_base     <= 10'(X0);
      y_base     <= 10'(Y0);
      sentido    <= 1'b1;
      passo      <= 1'b0;
      vivos      <= 4'(N);
      onda_limpa <= 1'b0;
      invadiu    <= 1'b0;
    end else begin
      passo <= 1'b0;
      case (state)
        IDLE: begin
          if (count_en) begin
            if (tick_done) begin
              tick <= 24'd0;
              idx  <= '0;
              col  <= '0;
              row  <= '0;
              cmin <= CW'(COLS - 1);
              cmax <= '0;
              rmax <= '0;
              cnt  <= 4'd0;
            end else begin
              tick <= tick + 24'd1;
            end
          end
        end

        SCAN: begin
          if (live) begin
            cnt  <= cnt + 4'd1;
            rmax <= row;
            if (col < cmin) cmin <= col;
            if (col > cmax) cmax <= col;
          end
          idx <= idx + IW'(1);
          if (col == CW'(COLS - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end

        MOVE: begin
          vivos   <= cnt;
          periodo <= 24'(DIV_MIN) + 24'(cnt) * 24'(DIV_STEP);
          if (rule_clear) begin
            onda_limpa <= 1'b1;
          end else if (rule_inv) begin
            invadiu <= 1'b1;
          end else if (rule_drop_r || rule_drop_l) begin
            y_base  <= y_base + 10'(DY);
            sentido <= ~sentido;
            passo   <= 1'b1;
          end else begin
            x_base <= sentido ? x_base + 10'(DX) : x_base - 10'(DX);
            passo  <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_horda_ctrl.sv
// Directed bench for horda_ctrl: four instances (nominal, right edge, narrowed
// wave near the edge, invasion) with a step scoreboard on the nominal one.
`default_nettype none

module tb_horda_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   r0, r2, r3;

  typedef struct {
    int cyc;
    int x;
    int y;
    int s;
  } step_t;

  step_t sb[$];

  horda_ctrl_if #(.N(8)) b0 ();
  horda_ctrl_if #(.N(8)) b1 ();
  horda_ctrl_if #(.N(8)) b2 ();
  horda_ctrl_if #(.N(8)) b3 ();

  horda_ctrl #(.DIV_MIN(4), .DIV_STEP(1))
    u0 (.CLOCK_50(clk), .resetInimigo(rst), .bus(b0));
  horda_ctrl #(.DIV_MIN(4), .DIV_STEP(1), .X0(458))
    u1 (.CLOCK_50(clk), .resetInimigo(rst), .bus(b1));
  horda_ctrl #(.DIV_MIN(4), .DIV_STEP(1), .X0(508))
    u2 (.CLOCK_50(clk), .resetInimigo(rst), .bus(b2));
  horda_ctrl #(.DIV_MIN(4), .DIV_STEP(1), .Y0(380))
    u3 (.CLOCK_50(clk), .resetInimigo(rst), .bus(b3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input int c, input int x, input int y, input int s);
    step_t e;
    e.cyc = c; e.x = x; e.y = y; e.s = s;
    sb.push_back(e);
  endtask

  // Every passo on the nominal instance must match the oldest expected step.
  always @(negedge clk) begin
    step_t e;
    if (b0.passo === 1'b1) begin
      chk("passo_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("step_cycle",   32'(cyc),        32'(e.cyc));
        chk("step_x_base",  32'(b0.x_base),  32'(e.x));
        chk("step_y_base",  32'(b0.y_base),  32'(e.y));
        chk("step_sentido", 32'(b0.sentido), 32'(e.s));
      end
    end
  end

  initial begin
    b0.pausa = 1'b0; b0.vivo = 8'hFF;
    b1.pausa = 1'b0; b1.vivo = 8'hFF;
    b2.pausa = 1'b0; b2.vivo = 8'h77;
    b3.pausa = 1'b0; b3.vivo = 8'hFF;

    #2 rst = 1'b1;
    #1;
    chk("rst_x_base",     32'(b0.x_base),     32'd100);
    chk("rst_y_base",     32'(b0.y_base),     32'd40);
    chk("rst_sentido",    32'(b0.sentido),    32'd1);
    chk("rst_passo",      32'(b0.passo),      32'd0);
    chk("rst_vivos",      32'(b0.vivos),      32'd8);
    chk("rst_onda_limpa", 32'(b0.onda_limpa), 32'd0);
    chk("rst_invadiu",    32'(b0.invadiu),    32'd0);

    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    r0 = cyc;
    push(r0 + 21, 102, 40, 1);
    push(r0 + 42, 104, 40, 1);
    push(r0 + 63, 106, 40, 1);

    wait_cyc(r0 + 21);
    chk("edge_s1_passo",   32'(b1.passo),   32'd1);
    chk("edge_s1_x",       32'(b1.x_base),  32'd460);
    chk("edge_s1_sentido", 32'(b1.sentido), 32'd1);
    chk("narrow_s1_passo", 32'(b2.passo),   32'd1);
    chk("narrow_s1_x",     32'(b2.x_base),  32'd510);
    chk("narrow_s1_vivos", 32'(b2.vivos),   32'd6);
    chk("inv_flag",        32'(b3.invadiu), 32'd1);
    chk("inv_no_passo",    32'(b3.passo),   32'd0);
    chk("inv_x_held",      32'(b3.x_base),  32'd100);
    chk("inv_y_held",      32'(b3.y_base),  32'd380);

    wait_cyc(r0 + 40);
    chk("narrow_s2_passo",   32'(b2.passo),   32'd1);
    chk("narrow_s2_y",       32'(b2.y_base),  32'd60);
    chk("narrow_s2_x",       32'(b2.x_base),  32'd510);
    chk("narrow_s2_sentido", 32'(b2.sentido), 32'd0);

    wait_cyc(r0 + 42);
    chk("edge_s2_passo",   32'(b1.passo),   32'd1);
    chk("edge_s2_x",       32'(b1.x_base),  32'd460);
    chk("edge_s2_y",       32'(b1.y_base),  32'd60);
    chk("edge_s2_sentido", 32'(b1.sentido), 32'd0);

    wait_cyc(r0 + 63);
    chk("edge_s3_passo", 32'(b1.passo),  32'd1);
    chk("edge_s3_x",     32'(b1.x_base), 32'd458);
    b0.vivo = 8'h77;
    push(r0 + 84, 108, 40, 1);
    push(r0 + 103, 110, 40, 1);

    wait_cyc(r0 + 84);
    chk("kill_vivos", 32'(b0.vivos), 32'd6);

    wait_cyc(r0 + 103);
    b0.pausa = 1'b1;
    push(r0 + 172, 112, 40, 1);
    wait_cyc(r0 + 153);
    b0.pausa = 1'b0;

    wait_cyc(r0 + 172);
    b0.vivo = 8'h00;

    wait_cyc(r0 + 191);
    chk("clear_flag",     32'(b0.onda_limpa), 32'd1);
    chk("clear_vivos",    32'(b0.vivos),      32'd0);
    chk("clear_no_passo", 32'(b0.passo),      32'd0);
    chk("clear_x",        32'(b0.x_base),     32'd112);

    wait_cyc(r0 + 291);
    chk("frozen_x",    32'(b0.x_base),     32'd112);
    chk("frozen_flag", 32'(b0.onda_limpa), 32'd1);

    rst = 1'b1;
    #1;
    chk("rst2_onda_limpa", 32'(b0.onda_limpa), 32'd0);
    chk("rst2_x_base",     32'(b0.x_base),     32'd100);
    chk("rst2_vivos",      32'(b0.vivos),      32'd8);
    b0.vivo = 8'hFF;
    @(posedge clk); #1 rst = 1'b0;
    r2 = cyc;
    push(r2 + 21, 102, 40, 1);

    // Second step's SCAN begins after edge r2+33; index 4 is current after r2+37.
    wait_cyc(r2 + 37);
    rst = 1'b1;
    #1;
    chk("midscan_x_base",  32'(b0.x_base),  32'd100);
    chk("midscan_y_base",  32'(b0.y_base),  32'd40);
    chk("midscan_sentido", 32'(b0.sentido), 32'd1);
    chk("midscan_passo",   32'(b0.passo),   32'd0);
    chk("midscan_vivos",   32'(b0.vivos),   32'd8);
    @(posedge clk); #1 rst = 1'b0;
    r3 = cyc;
    push(r3 + 21, 102, 40, 1);
    push(r3 + 42, 104, 40, 1);

    wait_cyc(r3 + 50);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
